// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC front end (pre-emphasis, framing, windowing).
// The window stage imports FRAME_LEN_DEF from here so both sides agree on frame size.
package mfcc_pkg;

   typedef logic signed [15:0] sample_t;

   typedef enum logic {
      FILL,
      STEADY
   } frame_state_t;

   localparam int FRAME_LEN_DEF = 306;
   localparam int HOP_DEF       = 153;
   localparam int ALPHA_Q15_DEF = 31785;

   function automatic sample_t sat16(input logic signed [16:0] v);
      if (v > 17'sd32767) begin
         return 16'sh7fff;
      end else if (v < -17'sd32768) begin
         return 16'sh8000;
      end else begin
         return v[15:0];
      end
   endfunction

endpackage

// File: rtl/preemph_filter.sv
// First-order pre-emphasis y = x - alpha*x_prev with a saturated 16-bit result.
// x_prev advances only on accepted samples; clear restarts the stream history.
module preemph_filter
   import mfcc_pkg::*;
#(
   parameter int ALPHA_Q15 = ALPHA_Q15_DEF
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    clear,
   input  logic    en,
   input  sample_t sample,
   output sample_t y
);

   localparam logic signed [31:0] ALPHA = 32'(ALPHA_Q15);

   sample_t            x_prev;
   logic signed [31:0] prod;
   logic signed [16:0] corr;
   logic signed [16:0] diff;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         x_prev <= '0;
      end else if (en) begin
         x_prev <= sample;
      end
   end

   // |alpha*x_prev| >> 15 stays below 2^15, so the difference fits in 17 bits
   assign prod = ALPHA * 32'(x_prev);
   assign corr = 17'(prod >>> 15);
   assign diff = 17'(sample) - corr;
   assign y    = sat16(diff);

endmodule

// File: rtl/preemph_framer.sv
// Pre-emphasis plus overlapping framer feeding the Hamming window stage.
// Each frame is snapshotted from a sliding buffer and held under valid/ready.
module preemph_framer
   import mfcc_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int HOP       = HOP_DEF,
   parameter int ALPHA_Q15 = ALPHA_Q15_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  sample_t     sample_i,
   input  logic        sample_valid_i,
   output logic        sample_ready_o,
   output sample_t     frame_o [FRAME_LEN],
   output logic        frame_valid_o,
   input  logic        frame_ready_i,
   output logic [15:0] frame_count_o
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   frame_state_t     state;
   frame_state_t     state_nxt;
   logic [CNT_W-1:0] fill_cnt;
   logic [CNT_W-1:0] hop_cnt;
   sample_t          shift_buf [FRAME_LEN];
   sample_t          y;
   logic             run;
   logic             boundary;
   logic             accept;
   logic             capture;

   preemph_filter #(
      .ALPHA_Q15(ALPHA_Q15)
   ) u_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear_i),
      .en    (accept),
      .sample(sample_i),
      .y     (y)
   );

   // Stall only when the next sample would overwrite a frame still waiting downstream
   assign sample_ready_o = run && !(boundary && frame_valid_o && !frame_ready_i);
   assign accept         = sample_valid_i && sample_ready_o && !clear_i;
   assign capture        = accept && boundary;

   always_comb begin
      state_nxt = state;
      boundary  = 1'b0;
      case (state)
         FILL: begin
            boundary = (fill_cnt == CNT_W'(FRAME_LEN - 1));
            if (capture) begin
               state_nxt = STEADY;
            end
         end
         STEADY: begin
            boundary = (hop_cnt == CNT_W'(HOP - 1));
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         run           <= rst_n;
         state         <= FILL;
         fill_cnt      <= '0;
         hop_cnt       <= '0;
         frame_valid_o <= 1'b0;
         frame_count_o <= '0;
      end else begin
         run   <= 1'b1;
         state <= state_nxt;
         if (accept) begin
            if (state == FILL) begin
               fill_cnt <= fill_cnt + 1'b1;
            end else begin
               hop_cnt <= boundary ? '0 : hop_cnt + 1'b1;
            end
         end
         if (capture) begin
            frame_count_o <= frame_count_o + 16'd1;
         end
         frame_valid_o <= capture || (frame_valid_o && !frame_ready_i);
      end
   end

   // The snapshot includes the sample accepted on the boundary beat itself
   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            shift_buf[i] <= '0;
            frame_o[i]   <= '0;
         end
      end else begin
         if (accept) begin
            for (int i = 0; i < FRAME_LEN - 1; i++) begin
               shift_buf[i] <= shift_buf[i+1];
            end
            shift_buf[FRAME_LEN-1] <= y;
         end
         if (capture) begin
            for (int i = 0; i < FRAME_LEN - 1; i++) begin
               frame_o[i] <= shift_buf[i+1];
            end
            frame_o[FRAME_LEN-1] <= y;
         end
      end
   end

endmodule

// File: tb/tb_preemph_framer.sv
// Directed bench for preemph_framer: fill, saturation, overlap, backpressure,
// mid-fill clear and reset-while-valid, checked against hand values and a small model.
module tb_preemph_framer;
   import mfcc_pkg::*;

   localparam int FL = 306;
   localparam int HP = 153;

   logic        clk;
   logic        rst_n;
   logic        clear_i;
   sample_t     sample_i;
   logic        sample_valid_i;
   logic        sample_ready_o;
   sample_t     frame_o [FL];
   logic        frame_valid_o;
   logic        frame_ready_i;
   logic [15:0] frame_count_o;

   int tests;
   int fails;
   int mbuf  [FL];
   int saved [FL];
   int mprev;
   int mfill;
   int mhop;
   int mcount;
   bit msteady;

   preemph_framer #(
      .FRAME_LEN(FL),
      .HOP      (HP),
      .ALPHA_Q15(31785)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear_i       (clear_i),
      .sample_i      (sample_i),
      .sample_valid_i(sample_valid_i),
      .sample_ready_o(sample_ready_o),
      .frame_o       (frame_o),
      .frame_valid_o (frame_valid_o),
      .frame_ready_i (frame_ready_i),
      .frame_count_o (frame_count_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, %0d tests run", tests);
      $fatal(1, "watchdog expired");
   end

   function automatic int ref_y(input int x, input int xp);
      int q;
      int y;
      q = (31785 * xp) >>> 15;
      y = x - q;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      return y;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < FL; i++) mbuf[i] = 0;
      mprev   = 0;
      mfill   = 0;
      mhop    = 0;
      mcount  = 0;
      msteady = 1'b0;
   endtask

   task automatic model_beat(input int x);
      int y;
      y = ref_y(x, mprev);
      mprev = x;
      for (int i = 0; i < FL - 1; i++) mbuf[i] = mbuf[i+1];
      mbuf[FL-1] = y;
      if (!msteady) begin
         mfill++;
         if (mfill == FL) begin
            msteady = 1'b1;
            mhop    = 0;
            mcount++;
         end
      end else begin
         mhop++;
         if (mhop == HP) begin
            mhop = 0;
            mcount++;
         end
      end
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_frame(input string tag, input int exp [FL]);
      int bad;
      bad = 0;
      for (int i = FL - 1; i >= 0; i--) begin
         if (32'(frame_o[i]) !== exp[i]) bad = i;
      end
      chk($sformatf("%s[%0d]", tag, bad), 32'(frame_o[bad]), exp[bad]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Offers one sample, waits (bounded) for ready, and returns at the negedge after acceptance
   task automatic beat(input int x);
      int guard;
      guard          = 0;
      sample_i       = 16'(x);
      sample_valid_i = 1'b1;
      #1;
      while (sample_ready_o !== 1'b1 && guard < 1000) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 1000) chk("beat_ready_timeout", 32'(sample_ready_o), 1);
      @(negedge clk);
      sample_valid_i = 1'b0;
      model_beat(x);
   endtask

   task automatic pulse_clear();
      clear_i = 1'b1;
      idle(1);
      clear_i = 1'b0;
      model_reset();
   endtask

   function automatic int bp_val(input int n);
      return ((n * 97) % 4001) - 2000;
   endfunction

   function automatic int cl_val(input int n);
      return 500 - n * 3;
   endfunction

   initial begin
      tests          = 0;
      fails          = 0;
      rst_n          = 1'b0;
      clear_i        = 1'b0;
      sample_i       = '0;
      sample_valid_i = 1'b0;
      frame_ready_i  = 1'b0;
      model_reset();

      // reset state
      idle(2);
      chk("rst_frame_valid", 32'(frame_valid_o), 0);
      chk("rst_frame_count", 32'(frame_count_o), 0);
      chk("rst_sample_ready", 32'(sample_ready_o), 0);
      chk("rst_frame0", 32'(frame_o[0]), 0);
      rst_n = 1'b1;
      idle(1);
      chk("ready_after_release", 32'(sample_ready_o), 1);

      // constant input: first y = 1000, rest 1000 - 970 = 30
      for (int n = 0; n < FL - 1; n++) beat(1000);
      chk("const_no_early_frame", 32'(frame_valid_o), 0);
      beat(1000);
      chk("const_frame_valid", 32'(frame_valid_o), 1);
      chk("const_frame_count", 32'(frame_count_o), 1);
      chk("const_frame0", 32'(frame_o[0]), 1000);
      chk("const_frame1", 32'(frame_o[1]), 30);
      chk("const_frame305", 32'(frame_o[FL-1]), 30);
      check_frame("const_frame", mbuf);
      idle(2);
      chk("const_hold_valid", 32'(frame_valid_o), 1);
      chk("const_ready_while_pending", 32'(sample_ready_o), 1);

      // one-cycle reset while a frame is pending
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      chk("rstpend_frame_valid", 32'(frame_valid_o), 0);
      chk("rstpend_frame_count", 32'(frame_count_o), 0);
      model_reset();
      idle(1);

      // saturation: 32767, then -32768 (raw -64552), then 0 -> 31785
      frame_ready_i = 1'b1;
      beat(32767);
      beat(-32768);
      for (int n = 2; n < FL; n++) beat(0);
      chk("sat_frame_valid", 32'(frame_valid_o), 1);
      chk("sat_y0", 32'(frame_o[0]), 32767);
      chk("sat_y1", 32'(frame_o[1]), -32768);
      chk("sat_y2", 32'(frame_o[2]), 31785);
      check_frame("sat_frame", mbuf);
      idle(1);
      chk("sat_consumed", 32'(frame_valid_o), 0);

      // clear while idle
      pulse_clear();
      chk("clear_count", 32'(frame_count_o), 0);
      chk("clear_ready", 32'(sample_ready_o), 1);

      // ramp with overlapping frames
      for (int n = 0; n < 2 * FL; n++) begin
         beat(n);
         if (n == FL - 1) begin
            chk("ramp_f1_valid", 32'(frame_valid_o), 1);
            chk("ramp_f1_y1", 32'(frame_o[1]), 1);
            check_frame("ramp_f1", mbuf);
            saved = mbuf;
         end
         if (n == FL) chk("ramp_f1_consumed", 32'(frame_valid_o), 0);
         if (n == FL + HP - 1) begin
            chk("ramp_f2_valid", 32'(frame_valid_o), 1);
            chk("ramp_f2_first", 32'(frame_o[0]), 6);
            chk("ramp_overlap", 32'(frame_o[0]), saved[HP]);
            check_frame("ramp_f2", mbuf);
         end
      end
      chk("ramp_count", 32'(frame_count_o), 3);
      chk("ramp_count_model", 32'(frame_count_o), mcount);
      check_frame("ramp_f3", mbuf);

      // backpressure: first frame left pending
      pulse_clear();
      frame_ready_i = 1'b0;
      for (int n = 0; n < FL; n++) beat(bp_val(n));
      chk("bp_f1_valid", 32'(frame_valid_o), 1);
      check_frame("bp_f1", mbuf);
      saved = mbuf;
      for (int n = FL; n < FL + HP - 1; n++) begin
         beat(bp_val(n));
         if (n == FL + HP - 3) chk("bp_ready_before_boundary", 32'(sample_ready_o), 1);
      end
      #1;
      chk("bp_ready_low", 32'(sample_ready_o), 0);
      sample_i       = 16'(bp_val(FL + HP - 1));
      sample_valid_i = 1'b1;
      idle(3);
      chk("bp_hold_valid", 32'(frame_valid_o), 1);
      chk("bp_hold_count", 32'(frame_count_o), 1);
      check_frame("bp_hold_frame", saved);
      frame_ready_i = 1'b1;
      #1;
      chk("bp_ready_resume", 32'(sample_ready_o), 1);
      beat(bp_val(FL + HP - 1));
      chk("bp_f2_valid", 32'(frame_valid_o), 1);
      chk("bp_f2_count", 32'(frame_count_o), 2);
      check_frame("bp_f2", mbuf);
      idle(1);

      // clear mid-fill on the same cycle as a valid sample
      pulse_clear();
      for (int n = 0; n < 199; n++) beat(cl_val(n));
      clear_i        = 1'b1;
      sample_i       = 16'(777);
      sample_valid_i = 1'b1;
      idle(1);
      clear_i        = 1'b0;
      sample_valid_i = 1'b0;
      model_reset();
      chk("clr_count", 32'(frame_count_o), 0);
      chk("clr_valid", 32'(frame_valid_o), 0);
      beat(-1234);
      for (int n = 1; n < FL - 1; n++) beat(cl_val(n));
      chk("clr_no_early_frame", 32'(frame_valid_o), 0);
      beat(cl_val(FL - 1));
      chk("clr_frame_valid", 32'(frame_valid_o), 1);
      chk("clr_first_raw", 32'(frame_o[0]), -1234);
      chk("clr_count_after", 32'(frame_count_o), 1);
      check_frame("clr_frame", mbuf);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/preemph_framer.md
Name: preemph_framer

Overview:
- Streaming front end that sits directly upstream of the Hamming window stage.
- Accepts one 16-bit PCM sample per valid/ready beat and applies first-order pre-emphasis, y[n] = x[n] − α·x[n−1].
- Assembles overlapping frames of FRAME_LEN samples, advancing HOP samples per frame.
- Presents each frame as a registered parallel array, held under a valid/ready handshake until the window stage accepts it.

Parameters:
- FRAME_LEN, 306: samples per frame. Must match the window stage's frame size.
- HOP, 153: samples between consecutive frame starts. Constraint: 1 ≤ HOP ≤ FRAME_LEN.
- ALPHA_Q15, 31785: pre-emphasis coefficient in Q1.15 (0.97).

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: synchronous, active-low reset.
- clear_i, input, 1: synchronous stream restart (start of a new utterance).
- sample_i, input, 16 signed: PCM sample.
- sample_valid_i, input, 1: sample_i is valid.
- sample_ready_o, output, 1: block can accept a sample.
- frame_o, output, FRAME_LEN x 16 signed: pre-emphasized frame; index 0 is the oldest sample.
- frame_valid_o, output, 1: frame_o is valid.
- frame_ready_i, input, 1: downstream accepts the frame.
- frame_count_o, output, 16: frames emitted since reset/clear; wraps modulo 2^16.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values when rst_n=0 at a clk edge:
  - frame_valid_o=0, frame_o all 0, frame_count_o=0, sample_ready_o=0.
  - x_prev=0, shift buffer all 0, state=FILL, fill/hop counters=0.
  - sample_ready_o goes to 1 on the first cycle after reset release.
- clear_i=1 has the same effect as reset except sample_ready_o=1. It overrides a simultaneous sample beat or frame acceptance.
- Accept rule: a sample is accepted when sample_valid_i && sample_ready_o.
- Pre-emphasis, on each accepted sample:
  - prod = ALPHA_Q15 * x_prev (32-bit signed).
  - y = sample_i − (prod >>> 15), computed at 17 bits, then saturated to [−32768, 32767].
  - x_prev ← sample_i.
  - y shifts into the FRAME_LEN-deep buffer at the newest end (index FRAME_LEN−1); the oldest sample drops out.
- State machine:
  - FILL: count accepted samples. On the FRAME_LEN-th accepted sample, capture the snapshot and move to STEADY with hop_cnt=0.
  - STEADY: hop_cnt increments per accepted sample. On the HOP-th sample, capture the snapshot and reset hop_cnt to 0.
- Snapshot:
  - Capture = buffer contents including the sample accepted in that cycle, written into frame_o.
  - frame_valid_o=1 the following cycle, so latency is 1 cycle from the boundary sample beat.
  - frame_count_o increments in the same cycle as the capture.
- Output handshake:
  - frame_o and frame_valid_o hold stable while frame_valid_o && !frame_ready_i.
  - frame_valid_o clears on acceptance unless a capture occurs in the same cycle, in which case it stays 1 and frame_o takes the new frame.
- Backpressure: sample_ready_o=0 only when the next accepted sample would be a frame boundary and frame_valid_o=1 && !frame_ready_i. Otherwise it is 1, so the buffer keeps filling while a frame is pending.
  - sample_ready_o must not depend combinationally on sample_valid_i.
- HOP=FRAME_LEN: frames are non-overlapping. HOP=1: a frame is emitted every sample after fill.

Decomposition:
- Shared package mfcc_pkg holds:
  - sample_t (logic signed [15:0]).
  - FRAME_LEN and HOP defaults.
  - ALPHA_Q15.
  - A sat16 function for saturating 17-bit signed values to 16 bits.
- The window stage uses the same FRAME_LEN constant.
- One sub-module: preemph_filter, a purely sequential x_prev register plus the saturating arithmetic, with an enable and a clear input.

Test Plan:
- Reset, then 306 beats of sample=1000 → frame_valid_o rises 1 cycle after beat 306; frame_o[0]=1000, frame_o[1..305]=30; frame_count_o=1.
- Saturation: sample 32767 then −32768 → y values are 32767 and −32768 (raw −64552 clamped).
- Overlap: ramp sample=n for n=0..611 with frame_ready_i=1 → frames 1, 2 and 3 complete at beats 306, 459 and 612.
  - Frame 2's frame_o[0] equals frame 1's frame_o[153].
  - frame_count_o=3.
- Backpressure: frame_ready_i=0 after the first frame → sample_ready_o drops exactly before beat 459, and frame_o stays stable.
  - Raising frame_ready_i resumes input, and the second frame matches the reference model.
- clear_i asserted mid-FILL (beat 200) alongside a valid sample → the sample is discarded and the counters reset.
  - The next frame appears only after 306 new beats, and its first y equals the raw sample (x_prev=0).
- rst_n low for 1 cycle while frame_valid_o=1 → frame_valid_o=0 and frame_count_o=0 on the next cycle.
